// File: rtl/axis_packer_pkg.sv
// Shared definitions for the AXI-Stream pixel packer: bus-ratio helpers and the beat layout.
package axis_packer_pkg;

  localparam int unsigned DEF_PIX_W = 16;
  localparam int unsigned DEF_OUT_W = 64;

  // Pixels per output beat.
  function automatic int unsigned calc_ratio(input int unsigned pix_w, input int unsigned out_w);
    return out_w / pix_w;
  endfunction

  // Byte-enable width of an output beat.
  function automatic int unsigned calc_keep_w(input int unsigned out_w);
    return out_w / 8;
  endfunction

  // Beat layout at the default bus width; the top re-declares the same layout at its own OUT_W.
  typedef struct packed {
    logic [DEF_OUT_W-1:0]   data;
    logic [DEF_OUT_W/8-1:0] keep;
    logic                   last;
    logic                   user;
  } beat_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer: registered output stage plus one spill register, payload width W.
module axis_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready_c,
  output logic         full_nxt_c,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         spill_valid_q, spill_valid_d;
  logic [W-1:0] spill_data_q, spill_data_d;
  logic         pop;
  logic         push;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    spill_valid_d = spill_valid_q;
    spill_data_d  = spill_data_q;
    pop           = out_valid_q && out_ready;
    in_ready_c    = !(out_valid_q && spill_valid_q) || pop;
    push          = in_valid && in_ready_c;
    // Output slot frees up: refill from spill first so ordering is preserved.
    if (pop || !out_valid_q) begin
      if (spill_valid_q) begin
        out_valid_d   = 1'b1;
        out_data_d    = spill_data_q;
        spill_valid_d = push;
        if (push) spill_data_d = in_data;
      end else begin
        out_valid_d = push;
        if (push) out_data_d = in_data;
      end
    end else if (push) begin
      spill_valid_d = 1'b1;
      spill_data_d  = in_data;
    end
    full_nxt_c = out_valid_d && spill_valid_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      spill_valid_q <= 1'b0;
      spill_data_q  <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      spill_valid_q <= spill_valid_d;
      spill_data_q  <= spill_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/axis_pixel_packer.sv
// Packs PIX_W pixels little-endian into OUT_W AXI-Stream beats with line/frame framing.
// Optional statistics ports are built when AXIS_PACKER_STATS_EN is defined.
module axis_pixel_packer
  import axis_packer_pkg::*;
#(
  parameter int unsigned PIX_W       = 16,
  parameter int unsigned OUT_W       = 64,
  parameter int unsigned LINE_PIX    = 1920,
  parameter int unsigned FRAME_LINES = 1080
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 sof_in,
  input  logic [PIX_W-1:0]     s_pix,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [OUT_W-1:0]     m_tdata,
  output logic [OUT_W/8-1:0]   m_tkeep,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 m_tuser
`ifdef AXIS_PACKER_STATS_EN
  ,
  output logic [31:0]          frame_cnt,
  output logic [15:0]          trunc_cnt
`endif
);

  localparam int unsigned RATIO  = calc_ratio(PIX_W, OUT_W);
  localparam int unsigned KEEP_W = calc_keep_w(OUT_W);
  localparam int unsigned LANE_W = $clog2(RATIO);
  localparam int unsigned PKB    = PIX_W / 8;
  localparam int unsigned CNT_W  = 12;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
  localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(LINE_PIX - 1);
  localparam logic [CNT_W-1:0]  LAST_LINE = CNT_W'(FRAME_LINES - 1);

  typedef struct packed {
    logic [OUT_W-1:0]  data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              user;
  } pkd_beat_t;

  pkd_beat_t         acc_q, acc_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              hold_q, hold_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
  logic              armed_q, armed_d;
  logic              s_ready_q, s_ready_d;

  logic              accept;
  logic [LANE_W-1:0] lane_sel;
  logic [CNT_W-1:0]  pix_idx;
  logic [CNT_W-1:0]  line_idx;
  logic              line_end;
  logic              complete;
  int unsigned       data_lsb;
  int unsigned       keep_lsb;
  pkd_beat_t         new_beat;
  logic              push;
  pkd_beat_t         push_beat;
  logic              skid_in_ready_c;
  logic              skid_full_nxt_c;
  pkd_beat_t         out_beat;

  always_comb begin
    acc_d      = acc_q;
    lane_d     = lane_q;
    hold_d     = hold_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    armed_d    = armed_q | sof_in;
    push       = 1'b0;
    push_beat  = acc_q;

    // A frame start restarts lane/pixel/line positioning for this very cycle's pixel.
    accept   = s_valid && s_ready_q;
    lane_sel = sof_in ? '0 : lane_q;
    pix_idx  = sof_in ? '0 : pix_cnt_q;
    line_idx = sof_in ? '0 : line_cnt_q;
    line_end = (pix_idx == LAST_PIX);
    complete = line_end || (lane_sel == LAST_LANE);
    data_lsb = 32'(lane_sel) * PIX_W;
    keep_lsb = 32'(lane_sel) * PKB;

    new_beat = acc_q;
    if (lane_sel == '0) begin
      new_beat.data = '0;
      new_beat.keep = '0;
      new_beat.user = sof_in | armed_q;
    end
    new_beat.data[data_lsb +: PIX_W] = s_pix;
    new_beat.keep[keep_lsb +: PKB]   = '1;
    new_beat.last                    = line_end;

    if (sof_in) begin
      lane_d     = '0;
      pix_cnt_d  = '0;
      line_cnt_d = '0;
    end

    // A beat parked in the accumulator goes out first; it is complete and never discarded.
    if (hold_q && skid_in_ready_c) begin
      push   = 1'b1;
      hold_d = 1'b0;
    end

    if (accept) begin
      acc_d = new_beat;
      if (lane_sel == '0) armed_d = 1'b0;
      if (complete) begin
        lane_d = '0;
        if (!push && skid_in_ready_c) begin
          push      = 1'b1;
          push_beat = new_beat;
        end else begin
          hold_d = 1'b1;
        end
      end else begin
        lane_d = lane_sel + LANE_W'(1);
      end
      if (line_end) begin
        pix_cnt_d = '0;
        if (line_idx == LAST_LINE) begin
          line_cnt_d = '0;
          armed_d    = 1'b1;
        end else begin
          line_cnt_d = line_idx + CNT_W'(1);
        end
      end else begin
        pix_cnt_d = pix_idx + CNT_W'(1);
      end
    end

    // Stall input only when a finished beat would have nowhere to go next cycle.
    s_ready_d = !(hold_d && skid_full_nxt_c);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q      <= '0;
      lane_q     <= '0;
      hold_q     <= 1'b0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      armed_q    <= 1'b1;
      s_ready_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      lane_q     <= lane_d;
      hold_q     <= hold_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      armed_q    <= armed_d;
      s_ready_q  <= s_ready_d;
    end
  end

  axis_skid_buf #(
    .W($bits(pkd_beat_t))
  ) u_skid (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (push),
    .in_data    (push_beat),
    .in_ready_c (skid_in_ready_c),
    .full_nxt_c (skid_full_nxt_c),
    .out_valid  (m_tvalid),
    .out_data   (out_beat),
    .out_ready  (m_tready)
  );

  assign s_ready = s_ready_q;
  assign m_tdata = out_beat.data;
  assign m_tkeep = out_beat.keep;
  assign m_tlast = out_beat.last;
  assign m_tuser = out_beat.user;

`ifdef AXIS_PACKER_STATS_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] trunc_cnt_q, trunc_cnt_d;

  // Saturating frame/truncation statistics.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    if (m_tvalid && m_tready && m_tuser && (frame_cnt_q != '1))
      frame_cnt_d = frame_cnt_q + 32'd1;
    if (sof_in && ((pix_cnt_q != '0) || (line_cnt_q != '0)) && (trunc_cnt_q != '1))
      trunc_cnt_d = trunc_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt_q <= '0;
      trunc_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign trunc_cnt = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_axis_pixel_packer.sv
// Scoreboard bench for axis_pixel_packer: 16-bit pixels, 64-bit beats, 6-pixel lines, 2-line frames.
module tb_axis_pixel_packer;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sof_in = 1'b0;
  logic [15:0] s_pix = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        m_tuser;
`ifdef AXIS_PACKER_STATS_EN
  logic [31:0] frame_cnt;
  logic [15:0] trunc_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  int   beat_no = 0;
  exp_t exp_q[$];
  bit   stall_prev = 1'b0;
  exp_t held;
  bit   dropped;

  always #5 clk = ~clk;

  axis_pixel_packer #(
    .PIX_W(16), .OUT_W(64), .LINE_PIX(6), .FRAME_LINES(2)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .sof_in   (sof_in),
    .s_pix    (s_pix),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tuser  (m_tuser)
`ifdef AXIS_PACKER_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .trunc_cnt(trunc_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    exp_t e;
    e.data = d; e.keep = k; e.last = l; e.user = u;
    exp_q.push_back(e);
  endtask

  // Monitor: pops expected beats on each handshake and checks payload stability under stall.
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    act.data = m_tdata; act.keep = m_tkeep; act.last = m_tlast; act.user = m_tuser;
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (act !== held) begin
          errors++;
          $display("FAIL stable: payload changed under stall got %h expected %h", act, held);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat%0d: unexpected beat data=%h keep=%h last=%b user=%b",
                   beat_no, act.data, act.keep, act.last, act.user);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL beat%0d: got data=%h keep=%h last=%b user=%b expected data=%h keep=%h last=%b user=%b",
                     beat_no, act.data, act.keep, act.last, act.user, e.data, e.keep, e.last, e.user);
          end
        end
        beat_no++;
      end
      stall_prev = m_tvalid && !m_tready;
      held = act;
    end
  end

  // Drive n consecutive pixel values; optional sof on the first and an m_tready stall window.
  task automatic send(input logic [15:0] first, input int n, input bit with_sof,
                      input int stall_at, input int stall_len, output bit saw_drop);
    int idx = 0;
    int cyc = 0;
    bit acc;
    saw_drop = 1'b0;
    @(posedge clk); #1;
    while (idx < n && cyc < 200) begin
      s_valid  = 1'b1;
      s_pix    = first + 16'(idx);
      sof_in   = with_sof && (idx == 0);
      m_tready = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      acc      = s_ready;
      if (!s_ready) saw_drop = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
    end
    s_valid  = 1'b0;
    sof_in   = 1'b0;
    m_tready = 1'b1;
    check("send_done", 64'(idx), 64'(n));
    if (stall_len == 0) check("throughput_cycles", 64'(cyc), 64'(n));
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    check("rst_tuser", 64'(m_tuser), 64'd0);
    check("rst_tdata", m_tdata, 64'd0);
    check("rst_tkeep", 64'(m_tkeep), 64'd0);
    check("rst_sready", 64'(s_ready), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("sready_after_rst", 64'(s_ready), 64'd1);

    // Full frame of two lines, continuous flow
    expect_beat(64'h0004_0003_0002_0001, 8'hFF, 1'b0, 1'b1);
    expect_beat(64'h0000_0000_0006_0005, 8'h0F, 1'b1, 1'b0);
    expect_beat(64'h000A_0009_0008_0007, 8'hFF, 1'b0, 1'b0);
    expect_beat(64'h0000_0000_000C_000B, 8'h0F, 1'b1, 1'b0);
    send(16'h0001, 12, 1'b0, 0, 0, dropped);
    wait_drain("drain_frame1");

    // Line counter wrapped: next line opens a new frame
    expect_beat(64'h0104_0103_0102_0101, 8'hFF, 1'b0, 1'b1);
    expect_beat(64'h0000_0000_0106_0105, 8'h0F, 1'b1, 1'b0);
    send(16'h0101, 6, 1'b0, 0, 0, dropped);
    wait_drain("drain_frame2");

    // Three pixels then sof on an accepted pixel: partial beat discarded
    send(16'h0201, 3, 1'b0, 0, 0, dropped);
    expect_beat(64'h0304_0303_0302_0301, 8'hFF, 1'b0, 1'b1);
    expect_beat(64'h0000_0000_0306_0305, 8'h0F, 1'b1, 1'b0);
    send(16'h0301, 6, 1'b1, 0, 0, dropped);
    wait_drain("drain_sof");
`ifdef AXIS_PACKER_STATS_EN
    check("trunc_cnt", 64'(trunc_cnt), 64'd1);
`endif

    // Ten-cycle m_tready stall mid-line across a frame wrap
    expect_beat(64'h0404_0403_0402_0401, 8'hFF, 1'b0, 1'b0);
    expect_beat(64'h0000_0000_0406_0405, 8'h0F, 1'b1, 1'b0);
    expect_beat(64'h040A_0409_0408_0407, 8'hFF, 1'b0, 1'b1);
    expect_beat(64'h0000_0000_040C_040B, 8'h0F, 1'b1, 1'b0);
    send(16'h0401, 12, 1'b0, 2, 10, dropped);
    check("sready_dropped", 64'(dropped), 64'd1);
    wait_drain("drain_stall");
`ifdef AXIS_PACKER_STATS_EN
    check("frame_cnt", 64'(frame_cnt), 64'd4);
`endif

    // Beat latency, then reset while a beat waits on the output
    m_tready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_pix   = 16'h0601 + 16'(i);
      if (i == 3) check("tvalid_before_last", 64'(m_tvalid), 64'd0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check("latency_tvalid", 64'(m_tvalid), 64'd1);
    check("latency_tdata", m_tdata, 64'h0604_0603_0602_0601);
    check("latency_tkeep", 64'(m_tkeep), 64'hFF);
    check("latency_tuser", 64'(m_tuser), 64'd0);
    #1;
    rstn = 1'b0;
    #1;
    check("midrst_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_tdata", m_tdata, 64'd0);
    check("midrst_tkeep", 64'(m_tkeep), 64'd0);
    check("midrst_tlast_tuser", 64'({m_tlast, m_tuser}), 64'd0);
    check("midrst_sready", 64'(s_ready), 64'd0);
    exp_q.delete();
    m_tready = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("sready_after_midrst", 64'(s_ready), 64'd1);
    expect_beat(64'h0504_0503_0502_0501, 8'hFF, 1'b0, 1'b1);
    expect_beat(64'h0000_0000_0506_0505, 8'h0F, 1'b1, 1'b0);
    send(16'h0501, 6, 1'b0, 0, 0, dropped);
    wait_drain("drain_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
